// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, oversampling constants, parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = 7;
  localparam int LAST_SAMPLE = 15;

  // Expected parity bit for a data word: even parity is the XOR of the data, odd is its inverse.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// rx synchronizer plus 3-sample majority filter updated on baud ticks; output rx_f.
// Latency SYNC_STAGES clk + 2 baud ticks per line edge; no backpressure (free-running).
module uart_rx_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic baud_clock,
  input  logic rx,
  output logic rx_f
);

  logic [SYNC_STAGES-1:0] sync;
  logic [1:0]             hist;
  logic                   cur;
  logic                   maj;

  assign cur = sync[SYNC_STAGES-1];
  assign maj = (hist[1] & hist[0]) | (hist[1] & cur) | (hist[0] & cur);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '1;
      hist <= '1;
      rx_f <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (baud_clock) begin
        hist <= {hist[0], cur};
        rx_f <= maj;
      end
    end
  end

endmodule

// File: rtl/uart_rx_async.sv
// UART receiver: 16x oversampled start/data/parity/stop framing with ready and sticky error flags.
// Byte visible on the stop-sample tick edge; no backpressure, an unread byte is overwritten and flagged.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       clear_errors,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  localparam int CNT_W = $clog2(OVERSAMPLE);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bidx;
  logic [7:0]       shreg;
  logic             par_pend;
  logic             rx_f;
  logic [2:0]       last_bit;
  logic [7:0]       data_w;
  logic             mid_hit;
  logic             last_hit;
  logic             load;

  uart_rx_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filter (
    .clk        (clk),
    .reset_n    (reset_n),
    .baud_clock (baud_clock),
    .rx         (rx),
    .rx_f       (rx_f)
  );

  assign last_bit = bit8 ? 3'd7 : 3'd6;
  assign data_w   = {bit8 & shreg[7], shreg[6:0]};
  assign mid_hit  = (cnt == CNT_W'(MID_SAMPLE));
  assign last_hit = (cnt == CNT_W'(LAST_SAMPLE));
  assign load     = baud_clock && (state == STOP) && last_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bidx        <= '0;
      shreg       <= '0;
      par_pend    <= 1'b0;
      rx_byte     <= '0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // A read coinciding with a load leaves the new byte marked unread.
      if (load) begin
        rx_byte  <= data_w;
        rx_ready <= 1'b1;
      end else if (read_rx_byte) begin
        rx_ready <= 1'b0;
      end

      if (load && par_pend)                       parity_err  <= 1'b1;
      else if (clear_errors)                      parity_err  <= 1'b0;
      if (load && !rx_f)                          framing_err <= 1'b1;
      else if (clear_errors)                      framing_err <= 1'b0;
      if (load && rx_ready && !read_rx_byte)      overflow    <= 1'b1;
      else if (clear_errors)                      overflow    <= 1'b0;

      if (baud_clock) begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (!rx_f) state <= START;
          end
          START: begin
            cnt <= cnt + 1'b1;
            if (mid_hit) begin
              cnt <= '0;
              if (!rx_f) begin
                state    <= DATA;
                bidx     <= '0;
                shreg    <= '0;
                par_pend <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            cnt <= cnt + 1'b1;
            if (last_hit) begin
              cnt         <= '0;
              shreg[bidx] <= rx_f;
              bidx        <= bidx + 3'd1;
              if (bidx >= last_bit) state <= parity_en ? PARITY : STOP;
            end
          end
          PARITY: begin
            cnt <= cnt + 1'b1;
            if (last_hit) begin
              cnt      <= '0;
              par_pend <= (rx_f != parity_bit(data_w, odd_n_even));
              state    <= STOP;
            end
          end
          STOP: begin
            cnt <= cnt + 1'b1;
            if (last_hit) begin
              cnt   <= '0;
              state <= rx_f ? IDLE : WAIT_HIGH;
            end
          end
          WAIT_HIGH: begin
            cnt <= '0;
            if (rx_f) state <= IDLE;
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
